// File: rtl/mode_counter_pkg.sv
// Shared mode encoding for the multi-mode counter and its next-value logic.
package mode_counter_pkg;

  typedef enum logic [1:0] {
    MODE_EVEN = 2'b00,
    MODE_ODD  = 2'b01,
    MODE_UP   = 2'b10,
    MODE_DOWN = 2'b11
  } mode_t;

endpackage

// File: rtl/mode_counter_next.sv
// Combinational successor of the counter value for a given mode, plus wrap flag.
// Define MODE_COUNTER_SATURATE_EN to clamp at the mode's extreme instead of wrapping.
module mode_counter_next
  import mode_counter_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] count_i,
  input  mode_t            mode_i,
  output logic [WIDTH-1:0] next_o,
  output logic             wrap_o
);

  localparam logic [WIDTH-1:0] MAX_VAL  = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] MAX_EVEN = {{(WIDTH-1){1'b1}}, 1'b0};

  logic [1:0]     step;
  logic [WIDTH:0] result;
  logic           boundary;

  // Even/odd modes take a short step when the current LSB is misaligned.
  always_comb begin
    step = 2'd1;
    case (mode_i)
      MODE_EVEN: step = count_i[0] ? 2'd1 : 2'd2;
      MODE_ODD:  step = count_i[0] ? 2'd2 : 2'd1;
      default:   step = 2'd1;
    endcase
  end

  // The extra MSB of the widened result is the carry (or borrow for DOWN).
  always_comb begin
    if (mode_i == MODE_DOWN) begin
      result = {1'b0, count_i} - (WIDTH+1)'(1);
    end else begin
      result = {1'b0, count_i} + (WIDTH+1)'(step);
    end
    boundary = result[WIDTH];
  end

  always_comb begin
    next_o = result[WIDTH-1:0];
    wrap_o = boundary;
`ifdef MODE_COUNTER_SATURATE_EN
    if (boundary) begin
      case (mode_i)
        MODE_EVEN: next_o = MAX_EVEN;
        MODE_DOWN: next_o = '0;
        default:   next_o = MAX_VAL;
      endcase
    end
`endif
  end

endmodule

// File: rtl/mode_counter.sv
// Multi-mode counter (even/odd/up/down) with load, enable and registered wrap pulse.
// Optional MODE_COUNTER_SATURATE_EN build clamps instead of wrapping (see mode_counter_next).
module mode_counter
  import mode_counter_pkg::*;
#(
  parameter int               WIDTH   = 4,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             wrap,
  output logic             parity_ok
);

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic [WIDTH-1:0] next_val;
  logic             next_wrap;
  mode_t            mode_s;

  assign mode_s = mode_t'(mode);

  mode_counter_next #(.WIDTH(WIDTH)) u_next (
    .count_i (count_q),
    .mode_i  (mode_s),
    .next_o  (next_val),
    .wrap_o  (next_wrap)
  );

  // Load beats enable; reset is applied in the flop block and beats both.
  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    if (load) begin
      count_d = load_val;
    end else if (en) begin
      count_d = next_val;
      wrap_d  = next_wrap;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= RST_VAL;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

  always_comb begin
    case (mode_s)
      MODE_EVEN: parity_ok = ~count_q[0];
      MODE_ODD:  parity_ok = count_q[0];
      default:   parity_ok = 1'b1;
    endcase
  end

  assign count = count_q;
  assign wrap  = wrap_q;

endmodule

// File: tb/tb_mode_counter.sv
// Self-checking bench for mode_counter: directed sequences then random traffic,
// compared against an integer reference model (handles MODE_COUNTER_SATURATE_EN too).
module tb_mode_counter;
  import mode_counter_pkg::*;

  localparam int               WIDTH   = 4;
  localparam int               MODULUS = 1 << WIDTH;
  localparam logic [WIDTH-1:0] RST_VAL = 4'd10;

  logic             clk = 1'b0;
  logic             rst, en, load;
  logic [1:0]       mode;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] count;
  logic             wrap, parity_ok;

  int   checks = 0;
  int   errors = 0;
  int   expCount;
  logic expWrap;

  mode_counter #(.WIDTH(WIDTH), .RST_VAL(RST_VAL)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .mode      (mode),
    .load      (load),
    .load_val  (load_val),
    .count     (count),
    .wrap      (wrap),
    .parity_ok (parity_ok)
  );

  always #5 clk = ~clk;

  // Reference model: target is the next even/odd/adjacent integer; out of range means wrap.
  task automatic modelStep(input logic r, input logic e, input logic l,
                           input logic [1:0] m, input int lv);
    int target;
    if (r) begin
      expCount = int'(RST_VAL);
      expWrap  = 1'b0;
    end else if (l) begin
      expCount = lv;
      expWrap  = 1'b0;
    end else if (!e) begin
      expWrap = 1'b0;
    end else begin
      case (m)
        2'b00:   target = (expCount / 2) * 2 + 2;
        2'b01:   target = ((expCount + 1) / 2) * 2 + 1;
        2'b10:   target = expCount + 1;
        default: target = expCount - 1;
      endcase
      if (target >= 0 && target < MODULUS) begin
        expCount = target;
        expWrap  = 1'b0;
      end else begin
        expWrap = 1'b1;
`ifdef MODE_COUNTER_SATURATE_EN
        if (target < 0)      expCount = 0;
        else if (m == 2'b00) expCount = MODULUS - 2;
        else                 expCount = MODULUS - 1;
`else
        expCount = (target + MODULUS) % MODULUS;
`endif
      end
    end
  endtask

  task automatic checkOutput(input string tag);
    logic [WIDTH-1:0] ec;
    logic             ep;
    ec = WIDTH'(expCount);
    if (mode == 2'b00)      ep = (expCount % 2 == 0);
    else if (mode == 2'b01) ep = (expCount % 2 == 1);
    else                    ep = 1'b1;

    checks++;
    assert (count === ec) else begin
      errors++;
      $error("[TB] FAIL %s count got %0d want %0d", tag, count, ec);
    end
    checks++;
    assert (wrap === expWrap) else begin
      errors++;
      $error("[TB] FAIL %s wrap got %0b want %0b", tag, wrap, expWrap);
    end
    checks++;
    assert (parity_ok === ep) else begin
      errors++;
      $error("[TB] FAIL %s parity_ok got %0b want %0b", tag, parity_ok, ep);
    end
  endtask

  // Drive on the falling edge, advance the model on the rising edge, check 1 ns later.
  task automatic applyStimulus(input logic r, input logic e, input logic l,
                               input logic [1:0] m, input int lv, input string tag);
    @(negedge clk);
    rst      = r;
    en       = e;
    load     = l;
    mode     = m;
    load_val = WIDTH'(lv);
    @(posedge clk);
    modelStep(r, e, l, m, lv);
    #1;
    checkOutput(tag);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; load = 1'b0; mode = MODE_EVEN; load_val = '0;
    expCount = 0;
    expWrap  = 1'b0;

    applyStimulus(1, 0, 0, MODE_EVEN, 0, "reset0");
    applyStimulus(1, 1, 1, MODE_EVEN, 3, "reset1");

    applyStimulus(0, 0, 1, MODE_EVEN, 0, "loadZero");
    for (int i = 0; i < 9; i++) applyStimulus(0, 1, 0, MODE_EVEN, 0, "evenRun");

    applyStimulus(0, 0, 1, MODE_EVEN, 0, "loadZero2");
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, 0, MODE_EVEN, 0, "evenTo6");
    for (int i = 0; i < 6; i++) applyStimulus(0, 1, 0, MODE_ODD, 0, "oddRun");

    applyStimulus(0, 0, 1, MODE_DOWN, 0, "loadDown");
    applyStimulus(0, 1, 0, MODE_DOWN, 0, "downWrap");
    applyStimulus(0, 1, 0, MODE_UP, 0, "upWrap");
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, MODE_UP, 0, "hold");

    applyStimulus(0, 1, 1, MODE_EVEN, 5, "loadOdd");
    applyStimulus(0, 1, 0, MODE_EVEN, 0, "align");
    applyStimulus(0, 1, 0, MODE_EVEN, 0, "evenAfterAlign");

    applyStimulus(0, 0, 1, MODE_UP, 9, "load9");
    applyStimulus(1, 1, 1, MODE_UP, 3, "rstOverLoad");

    applyStimulus(0, 0, 1, MODE_EVEN, 12, "load12");
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, 0, MODE_EVEN, 0, "evenTop");
    applyStimulus(0, 1, 0, MODE_ODD, 0, "oddTop");
    applyStimulus(0, 0, 1, MODE_DOWN, 1, "load1");
    for (int i = 0; i < 2; i++) applyStimulus(0, 1, 0, MODE_DOWN, 0, "downBottom");

    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom % 32) == 0, ($urandom % 4) != 0, ($urandom % 8) == 0,
                    2'($urandom), int'($urandom % MODULUS), "random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mode_counter.md
Name: mode_counter

Overview:
- Parametrised multi-mode counter; successor to the 4-bit odd/even counter.
- Counts in four modes: even, odd, up by 1, down by 1.
- Supports synchronous load, count enable, automatic parity realignment on mode change, and a registered wrap pulse.
- Used as a general sequencing/index counter in datapath and test structures.

Parameters:
- WIDTH, 4: counter width in bits; must be ≥2.
- RST_VAL, 0: count value applied on reset; must be < 2^WIDTH.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  count enable; count holds when low.
- mode  input  2  00 EVEN, 01 ODD, 10 UP, 11 DOWN.
- load  input  1  synchronous load strobe.
- load_val  input  WIDTH  value loaded when load=1.
- count  output  WIDTH  registered counter value.
- wrap  output  1  registered one-cycle pulse, high in the cycle after a wrap (or saturation) event.
- parity_ok  output  1  combinational; count LSB matches mode (EVEN: 0, ODD: 1); always 1 in UP/DOWN.

Behaviour:
- Reset: one clock; rst is synchronous and active-high.
- On rst: count=RST_VAL, wrap=0. rst overrides load and en, including mid-operation.
- Priority: rst > load > en.
- Load: load=1 sets count=load_val exactly, with no parity forcing, and wrap=0. en is ignored that cycle.
- Enabled update (en=1, load=0), all arithmetic modulo 2^WIDTH:
  - EVEN, count LSB=0: count+2.
  - EVEN, count LSB=1: count+1 (alignment step).
  - ODD, count LSB=1: count+2.
  - ODD, count LSB=0: count+1 (alignment step).
  - UP: count+1.
  - DOWN: count−1.
- wrap: set to 1 for exactly one cycle when the enabled update crosses the 2^WIDTH boundary:
  - EVEN: 2^W−2 → 0, or alignment 2^W−1 → 0.
  - ODD: 2^W−1 → 1.
  - UP: 2^W−1 → 0.
  - DOWN: 0 → 2^W−1.
  - Otherwise wrap=0. en=0 forces wrap=0 next cycle.
- Mode change: takes effect on the next enabled edge, evaluated against the current count. No extra latency and no internal mode register.
- Latency: one clock from en/load/rst to count.
- count is always a flop output. parity_ok is derived from count and mode only.

Optional Feature:
- Macro: MODE_COUNTER_SATURATE_EN.
- Defined: no wrap-around. Counting saturates at the mode's extreme:
  - EVEN holds 2^W−2.
  - ODD holds 2^W−1.
  - UP holds 2^W−1.
  - DOWN holds 0.
  - EVEN alignment from 2^W−1 goes to 2^W−2.
  - wrap pulses high on every enabled cycle in which an increment or decrement is blocked or clipped.
- Undefined: modulo wrap exactly as in Behaviour.
- The port list is identical in both builds.

Decomposition:
- Package mode_counter_pkg:
  - mode constants MODE_EVEN=2'b00, MODE_ODD=2'b01, MODE_UP=2'b10, MODE_DOWN=2'b11;
  - a 2-bit mode typedef.
- One combinational sub-module, mode_counter_next:
  - inputs: count, mode;
  - outputs: next value and wrap/saturate flag;
  - WIDTH parameter; contains the saturate ifdef.
- Top module holds the flops, the rst/load/en priority, and parity_ok.

Test Plan:
- WIDTH=4, rst=1 for 2 cycles, then en=1, mode=EVEN → count 0,2,4,…,14,0; wrap=1 only in the cycle after 14→0.
- EVEN counting, switch mode to ODD at count=6 → 7 (alignment), 9, 11, 13, 15, 1; wrap pulse after 15→1; parity_ok=0 for zero cycles after alignment.
- mode=DOWN from load_val=0 → count 15 with wrap=1; then mode=UP → 0 with wrap=1; en=0 for 3 cycles → count holds at 0, wrap=0.
- load=1, load_val=5, en=1, mode=EVEN → count=5, parity_ok=0; next cycles 6, 8.
- At count=9 assert rst=1 with load=1, load_val=3 → count=RST_VAL (0), wrap=0. With RST_VAL=10 build → count=10.
- MODE_COUNTER_SATURATE_EN, EVEN from load 12 → 14, 14, 14; wrap=1 on each blocked cycle. DOWN from 1 → 0, 0 with wrap=1 on the second.
